// File: rtl/gs_pkg.sv
// Shared definitions for the Gauss-Seidel sweep sequencer slice.
// Contents:
//   gs_state_t   - sequencer FSM states
//   NBR_*        - bit positions inside the 6-bit neighbour mask
//   N_DEF/IDX_W_DEF - default vector length and index width
//   nbr_mask_f   - neighbour-valid mask for element i of an n-element vector
package gs_pkg;

  localparam int N_DEF     = 16;
  localparam int IDX_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } gs_state_t;

  // Neighbour mask layout: even bits look forward, odd bits look back.
  localparam int NBR_W  = 6;
  localparam int NBR_P1 = 0;  // i+1
  localparam int NBR_M1 = 1;  // i-1
  localparam int NBR_P2 = 2;  // i+2
  localparam int NBR_M2 = 3;  // i-2
  localparam int NBR_P3 = 4;  // i+3
  localparam int NBR_M3 = 5;  // i-3

  // A neighbour is valid when its index stays inside 0..n-1, so the
  // computation unit zeroes coefficients at the vector edges from this mask.
  function automatic logic [NBR_W-1:0] nbr_mask_f(input int i, input int n);
    logic [NBR_W-1:0] m;
    m         = '0;
    m[NBR_P1] = (i + 1 <= n - 1);
    m[NBR_M1] = (i - 1 >= 0);
    m[NBR_P2] = (i + 2 <= n - 1);
    m[NBR_M2] = (i - 2 >= 0);
    m[NBR_P3] = (i + 3 <= n - 1);
    m[NBR_M3] = (i - 3 >= 0);
    return m;
  endfunction

endpackage

// File: rtl/gs_sweep_sequencer_if.sv
// Bus between the sweep sequencer and the solver datapath.
// Handshake semantics: there is no back-pressure. in_en is a one-cycle
// valid for a b sample (b_wr_en/b_wr_idx echo it the same cycle),
// issue_valid marks the single cycle in which the computation unit takes
// an operand set, wb_en marks the single cycle a result is written back,
// and out_valid marks each cycle x_out carries final result out_idx.
// Modports:
//   master - sequencer side (drives everything except in_en)
//   slave  - datapath / host side
// dbg_state exposes the sequencer FSM state for checkers.
interface gs_sweep_sequencer_if
  import gs_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int IT_W  = 6
);

  logic             in_en;
  logic             b_wr_en;
  logic [IDX_W-1:0] b_wr_idx;
  logic             issue_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [NBR_W-1:0] nbr_mask;
  logic             fwd_sel;
  logic             wb_en;
  logic [IDX_W-1:0] wb_idx;
  logic [IT_W-1:0]  iter_cnt;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             busy;
  logic             done;
  gs_state_t        dbg_state;

  modport master (
    input  in_en,
    output b_wr_en, b_wr_idx, issue_valid, rd_idx, nbr_mask, fwd_sel,
    output wb_en, wb_idx, iter_cnt, out_valid, out_idx, busy, done,
    output dbg_state
  );

  modport slave (
    output in_en,
    input  b_wr_en, b_wr_idx, issue_valid, rd_idx, nbr_mask, fwd_sel,
    input  wb_en, wb_idx, iter_cnt, out_valid, out_idx, busy, done,
    input  dbg_state
  );

endinterface

// File: rtl/gs_wb_delay.sv
// Write-back delay line: DEPTH-stage shift register of {valid, idx} that
// mirrors the computation-unit latency, so an issued element reappears on
// the write-back port exactly DEPTH cycles later.
// Ports:
//   clk, rst_in        - clock, asynchronous active-high reset
//   flush              - synchronous clear of every stage (drops in-flight writes)
//   in_valid, in_idx   - issue slot entering the line
//   wb_valid, wb_idx   - oldest stage, i.e. the write-back for this cycle
module gs_wb_delay #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_idx
);

  logic [DEPTH-1:0] v_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      v_q <= '0;
      for (int s = 0; s < DEPTH; s++) idx_q[s] <= '0;
    end else if (flush) begin
      v_q <= '0;
      for (int s = 0; s < DEPTH; s++) idx_q[s] <= '0;
    end else begin
      v_q[0]   <= in_valid;
      idx_q[0] <= in_idx;
      for (int s = 1; s < DEPTH; s++) begin
        v_q[s]   <= v_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  assign wb_valid = v_q[DEPTH-1];
  assign wb_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/gs_sweep_sequencer.sv
// Control FSM for the Gauss-Seidel iterative solver.
// Loads N b samples, then runs RUN full sweeps issuing one element every
// PIPE_LAT cycles to the pipelined computation unit, waits for the last
// write-back, streams the N results and pulses done.
// Ports:
//   clk     - clock
//   rst_in  - asynchronous active-high reset
//   bus     - gs_sweep_sequencer_if.master: load echo, issue/neighbour mask,
//             forwarding select, write-back, iteration count, result stream,
//             busy/done and FSM debug state
// A new in_en while sweeping, draining or outputting aborts the run and
// starts a fresh load with that sample as b[0].
module gs_sweep_sequencer
  import gs_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int RUN      = 50,
  parameter int PIPE_LAT = 1,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int IT_W     = 6
) (
  input  logic                clk,
  input  logic                rst_in,
  gs_sweep_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [1:0]       SLOT_MAX  = 2'(PIPE_LAT - 1);
  localparam logic [IT_W-1:0]  ITER_LAST = IT_W'(RUN - 1);

  gs_state_t        state;
  logic [IDX_W-1:0] load_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] out_idx;
  logic [1:0]       slot_cnt;
  logic [1:0]       drain_cnt;
  logic [IT_W-1:0]  iter_cnt;

  logic             abort;
  logic             issue;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;

  // Abort and the forced-low outputs must act in the same cycle as in_en,
  // hence these are decoded combinationally from the registered state.
  always_comb begin
    abort = 1'b0;
    issue = 1'b0;
    if (state == SWEEP || state == DRAIN || state == OUT) abort = bus.in_en;
    if (state == SWEEP && slot_cnt == 2'd0)                issue = !bus.in_en;
  end

  gs_wb_delay #(
    .DEPTH (PIPE_LAT),
    .IDX_W (IDX_W)
  ) u_wb_delay (
    .clk      (clk),
    .rst_in   (rst_in),
    .flush    (abort),
    .in_valid (issue),
    .in_idx   (rd_idx),
    .wb_valid (wb_valid),
    .wb_idx   (wb_idx)
  );

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      load_cnt  <= '0;
      rd_idx    <= '0;
      out_idx   <= '0;
      slot_cnt  <= '0;
      drain_cnt <= '0;
      iter_cnt  <= '0;
    end else if (abort) begin
      // The aborting sample is stored as b[0], so the count resumes at 1.
      state     <= LOAD;
      load_cnt  <= IDX_ONE;
      rd_idx    <= '0;
      out_idx   <= '0;
      slot_cnt  <= '0;
      drain_cnt <= '0;
      iter_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE, LOAD: begin
          if (bus.in_en) begin
            iter_cnt <= '0;
            if (load_cnt == IDX_MAX) begin
              state    <= SWEEP;
              load_cnt <= '0;
              rd_idx   <= '0;
              slot_cnt <= '0;
            end else begin
              state    <= LOAD;
              load_cnt <= load_cnt + IDX_ONE;
            end
          end
        end
        SWEEP: begin
          // rd_idx is held for the whole issue slot and steps at its end.
          if (slot_cnt == SLOT_MAX) begin
            slot_cnt <= '0;
            if (rd_idx == IDX_MAX) begin
              rd_idx   <= '0;
              iter_cnt <= iter_cnt + IT_W'(1);
              if (iter_cnt == ITER_LAST) begin
                state     <= DRAIN;
                drain_cnt <= '0;
              end
            end else begin
              rd_idx <= rd_idx + IDX_ONE;
            end
          end else begin
            slot_cnt <= slot_cnt + 2'd1;
          end
        end
        DRAIN: begin
          // PIPE_LAT cycles covers the last element's write-back.
          if (drain_cnt == SLOT_MAX) begin
            state   <= OUT;
            out_idx <= '0;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        OUT: begin
          if (out_idx == IDX_MAX) begin
            state   <= IDLE;
            out_idx <= '0;
          end else begin
            out_idx <= out_idx + IDX_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.b_wr_en     = bus.in_en;
    bus.b_wr_idx    = (state == IDLE || state == LOAD) ? load_cnt : '0;
    bus.issue_valid = issue;
    bus.rd_idx      = rd_idx;
    bus.nbr_mask    = issue ? nbr_mask_f(int'(rd_idx), N) : '0;
    // Issue spacing equals the unit latency, so x_{i-1} is on the
    // write-back bus in the very cycle element i is issued.
    bus.fwd_sel     = issue && wb_valid && (wb_idx == rd_idx - IDX_ONE) &&
                      (rd_idx != '0);
    bus.wb_en       = wb_valid;
    bus.wb_idx      = wb_idx;
    bus.iter_cnt    = iter_cnt;
    bus.out_valid   = (state == OUT) && !bus.in_en;
    bus.out_idx     = out_idx;
    bus.done        = (state == OUT) && !bus.in_en && (out_idx == IDX_MAX);
    bus.busy        = (state != IDLE);
    bus.dbg_state   = state;
  end

endmodule

// File: tb/tb_gs_sweep_sequencer.sv
// Bench for gs_sweep_sequencer: dut_a (RUN=2, PIPE_LAT=1) and dut_b
// (RUN=1, PIPE_LAT=2) run side by side; dut_a then covers abort, load
// stalls and asynchronous reset. Cycle c starts at the posedge where in_en
// for cycle c is applied; outputs are sampled at the following negedge.
module tb_gs_sweep_sequencer;
  import gs_pkg::*;

  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int IT_W  = 6;

  logic clk    = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk = ~clk;

  gs_sweep_sequencer_if #(.IDX_W(IDX_W), .IT_W(IT_W)) bus_a ();
  gs_sweep_sequencer_if #(.IDX_W(IDX_W), .IT_W(IT_W)) bus_b ();

  gs_sweep_sequencer #(.N(N), .RUN(2), .PIPE_LAT(1), .IDX_W(IDX_W), .IT_W(IT_W))
    dut_a (.clk(clk), .rst_in(rst_in), .bus(bus_a.master));
  gs_sweep_sequencer #(.N(N), .RUN(1), .PIPE_LAT(2), .IDX_W(IDX_W), .IT_W(IT_W))
    dut_b (.clk(clk), .rst_in(rst_in), .bus(bus_b.master));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Hand-computed snapshots of dut_a during the first run.
  typedef struct {
    int         cyc;
    logic       issue;
    logic [3:0] rd;
    logic [5:0] nbr;
    logic       fwd;
    logic       wb;
    logic [3:0] wbi;
    logic [5:0] iter;
    logic       ov;
    logic [3:0] oi;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [11];

  initial begin
    bus_a.in_en = 1'b0;
    bus_b.in_en = 1'b0;

    //             cyc iss  rd     nbr        fwd   wb    wbi     iter   ov    oi     busy  done
    tbl[0]  = '{0,  1'b0, 4'd0,  6'b000000, 1'b0, 1'b0, 4'd0,  6'd0, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[1]  = '{16, 1'b1, 4'd0,  6'b010101, 1'b0, 1'b0, 4'd0,  6'd0, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[2]  = '{17, 1'b1, 4'd1,  6'b010111, 1'b1, 1'b1, 4'd0,  6'd0, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[3]  = '{24, 1'b1, 4'd8,  6'b111111, 1'b1, 1'b1, 4'd7,  6'd0, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[4]  = '{31, 1'b1, 4'd15, 6'b101010, 1'b1, 1'b1, 4'd14, 6'd0, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[5]  = '{32, 1'b1, 4'd0,  6'b010101, 1'b0, 1'b1, 4'd15, 6'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[6]  = '{47, 1'b1, 4'd15, 6'b101010, 1'b1, 1'b1, 4'd14, 6'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[7]  = '{48, 1'b0, 4'd0,  6'b000000, 1'b0, 1'b1, 4'd15, 6'd2, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[8]  = '{49, 1'b0, 4'd0,  6'b000000, 1'b0, 1'b0, 4'd0,  6'd2, 1'b1, 4'd0,  1'b1, 1'b0};
    tbl[9]  = '{64, 1'b0, 4'd0,  6'b000000, 1'b0, 1'b0, 4'd0,  6'd2, 1'b1, 4'd15, 1'b1, 1'b1};
    tbl[10] = '{65, 1'b0, 4'd0,  6'b000000, 1'b0, 1'b0, 4'd0,  6'd2, 1'b0, 4'd0,  1'b0, 1'b0};

    // ---------------- reset state ----------------
    #3;
    chk("rst_a_busy",  0, 32'(bus_a.busy), 0);
    chk("rst_a_issue", 0, 32'(bus_a.issue_valid), 0);
    chk("rst_a_wb",    0, 32'(bus_a.wb_en), 0);
    chk("rst_a_ov",    0, 32'(bus_a.out_valid), 0);
    chk("rst_a_iter",  0, 32'(bus_a.iter_cnt), 0);
    chk("rst_a_state", 0, 32'(bus_a.dbg_state == IDLE), 1);
    chk("rst_b_busy",  0, 32'(bus_b.busy), 0);
    chk("rst_b_done",  0, 32'(bus_b.done), 0);
    chk("rst_b_wb",    0, 32'(bus_b.wb_en), 0);
    #9 rst_in = 1'b0;

    // ---------------- run A and run B together ----------------
    for (int c = 0; c <= 70; c++) begin
      @(posedge clk); #1;
      bus_a.in_en = (c <= 15);
      bus_b.in_en = (c <= 15);
      @(negedge clk);
      // dut_a: RUN=2, PIPE_LAT=1
      chk("a_b_wr_en", c, 32'(bus_a.b_wr_en), 32'(c <= 15));
      if (c <= 15) chk("a_b_wr_idx", c, 32'(bus_a.b_wr_idx), c);
      chk("a_issue", c, 32'(bus_a.issue_valid), 32'(c >= 16 && c <= 47));
      if (c >= 16 && c <= 47) begin
        chk("a_rd_idx", c, 32'(bus_a.rd_idx), (c - 16) % 16);
        chk("a_iter",   c, 32'(bus_a.iter_cnt), (c - 16) / 16);
        chk("a_fwd",    c, 32'(bus_a.fwd_sel), 32'((c - 16) % 16 != 0));
      end else begin
        chk("a_fwd_idle", c, 32'(bus_a.fwd_sel), 0);
        chk("a_nbr_idle", c, 32'(bus_a.nbr_mask), 0);
      end
      chk("a_wb_en", c, 32'(bus_a.wb_en), 32'(c >= 17 && c <= 48));
      if (c >= 17 && c <= 48) chk("a_wb_idx", c, 32'(bus_a.wb_idx), (c - 17) % 16);
      chk("a_out_valid", c, 32'(bus_a.out_valid), 32'(c >= 49 && c <= 64));
      if (c >= 49 && c <= 64) chk("a_out_idx", c, 32'(bus_a.out_idx), c - 49);
      chk("a_done", c, 32'(bus_a.done), 32'(c == 64));
      chk("a_busy", c, 32'(bus_a.busy), 32'(c >= 1 && c <= 64));
      for (int k = 0; k < 11; k++) begin
        if (tbl[k].cyc == c) begin
          chk("t_issue", c, 32'(bus_a.issue_valid), 32'(tbl[k].issue));
          chk("t_rd",    c, 32'(bus_a.rd_idx),      32'(tbl[k].rd));
          chk("t_nbr",   c, 32'(bus_a.nbr_mask),    32'(tbl[k].nbr));
          chk("t_fwd",   c, 32'(bus_a.fwd_sel),     32'(tbl[k].fwd));
          chk("t_wb",    c, 32'(bus_a.wb_en),       32'(tbl[k].wb));
          chk("t_wbi",   c, 32'(bus_a.wb_idx),      32'(tbl[k].wbi));
          chk("t_iter",  c, 32'(bus_a.iter_cnt),    32'(tbl[k].iter));
          chk("t_ov",    c, 32'(bus_a.out_valid),   32'(tbl[k].ov));
          chk("t_oi",    c, 32'(bus_a.out_idx),     32'(tbl[k].oi));
          chk("t_busy",  c, 32'(bus_a.busy),        32'(tbl[k].busy));
          chk("t_done",  c, 32'(bus_a.done),        32'(tbl[k].done));
        end
      end
      // dut_b: RUN=1, PIPE_LAT=2
      chk("b_issue", c, 32'(bus_b.issue_valid), 32'(c >= 16 && c <= 46 && c % 2 == 0));
      if (c >= 16 && c <= 46 && c % 2 == 0) begin
        chk("b_rd_idx", c, 32'(bus_b.rd_idx), (c - 16) / 2);
        chk("b_fwd",    c, 32'(bus_b.fwd_sel), 32'(c != 16));
        chk("b_iter",   c, 32'(bus_b.iter_cnt), 0);
      end
      chk("b_wb_en", c, 32'(bus_b.wb_en), 32'(c >= 18 && c <= 48 && c % 2 == 0));
      if (c >= 18 && c <= 48 && c % 2 == 0) chk("b_wb_idx", c, 32'(bus_b.wb_idx), (c - 18) / 2);
      chk("b_drain", c, 32'(bus_b.dbg_state == DRAIN), 32'(c >= 48 && c <= 49));
      chk("b_out_valid", c, 32'(bus_b.out_valid), 32'(c >= 50 && c <= 65));
      if (c >= 50 && c <= 65) chk("b_out_idx", c, 32'(bus_b.out_idx), c - 50);
      if (c >= 48) chk("b_iter_hold", c, 32'(bus_b.iter_cnt), 1);
      chk("b_done", c, 32'(bus_b.done), 32'(c == 65));
      chk("b_busy", c, 32'(bus_b.busy), 32'(c >= 1 && c <= 65));
    end

    // ---------------- abort during the first sweep (dut_a) ----------------
    bus_b.in_en = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      @(posedge clk); #1;
      bus_a.in_en = (c <= 15) || (c >= 30 && c <= 45);
      @(negedge clk);
      if (c == 0) chk("c_iter_held", c, 32'(bus_a.iter_cnt), 2);
      if (c == 1) chk("c_iter_clr",  c, 32'(bus_a.iter_cnt), 0);
      if (c == 29) begin
        chk("c_issue_pre", c, 32'(bus_a.issue_valid), 1);
        chk("c_rd_pre",    c, 32'(bus_a.rd_idx), 13);
      end
      if (c == 30) begin
        chk("c_issue_abort", c, 32'(bus_a.issue_valid), 0);
        chk("c_ov_abort",    c, 32'(bus_a.out_valid), 0);
        chk("c_bwr_abort",   c, 32'(bus_a.b_wr_en), 1);
        chk("c_bidx_abort",  c, 32'(bus_a.b_wr_idx), 0);
      end
      if (c == 31) begin
        chk("c_state_load", c, 32'(bus_a.dbg_state == LOAD), 1);
        chk("c_iter_abort", c, 32'(bus_a.iter_cnt), 0);
      end
      if (c >= 31 && c <= 45) begin
        chk("c_wb_flushed", c, 32'(bus_a.wb_en), 0);
        chk("c_no_issue",   c, 32'(bus_a.issue_valid), 0);
        chk("c_b_wr_idx",   c, 32'(bus_a.b_wr_idx), c - 30);
      end
      if (c == 46) begin
        chk("c_restart_state", c, 32'(bus_a.dbg_state == SWEEP), 1);
        chk("c_restart_issue", c, 32'(bus_a.issue_valid), 1);
        chk("c_restart_rd",    c, 32'(bus_a.rd_idx), 0);
        chk("c_restart_iter",  c, 32'(bus_a.iter_cnt), 0);
        chk("c_restart_wb",    c, 32'(bus_a.wb_en), 0);
      end
      if (c == 47) begin
        chk("c_wb_resume",  c, 32'(bus_a.wb_en), 1);
        chk("c_wbi_resume", c, 32'(bus_a.wb_idx), 0);
        chk("c_rd_resume",  c, 32'(bus_a.rd_idx), 1);
      end
    end

    // ---------------- reset mid-sweep, then stalled load ----------------
    #2 rst_in = 1'b1;
    #1;
    chk("d_rst_state", 0, 32'(bus_a.dbg_state == IDLE), 1);
    chk("d_rst_issue", 0, 32'(bus_a.issue_valid), 0);
    chk("d_rst_wb",    0, 32'(bus_a.wb_en), 0);
    #1 rst_in = 1'b0;
    for (int c = 0; c <= 109; c++) begin
      @(posedge clk); #1;
      bus_a.in_en = (c % 4 == 0) && (c <= 60);
      @(negedge clk);
      if (c <= 60 && c % 4 == 0) begin
        chk("d_b_wr_en",  c, 32'(bus_a.b_wr_en), 1);
        chk("d_b_wr_idx", c, 32'(bus_a.b_wr_idx), c / 4);
      end
      if (c <= 60 && c % 4 != 0) begin
        chk("d_gap_wr",    c, 32'(bus_a.b_wr_en), 0);
        chk("d_gap_state", c, 32'(bus_a.dbg_state == LOAD), 1);
      end
      if (c == 60) chk("d_last_load_issue", c, 32'(bus_a.issue_valid), 0);
      if (c == 61) begin
        chk("d_sweep_state", c, 32'(bus_a.dbg_state == SWEEP), 1);
        chk("d_sweep_issue", c, 32'(bus_a.issue_valid), 1);
        chk("d_sweep_rd",    c, 32'(bus_a.rd_idx), 0);
      end
      if (c == 109) begin
        chk("d_done", c, 32'(bus_a.done), 1);
        chk("d_ov",   c, 32'(bus_a.out_valid), 1);
        chk("d_oi",   c, 32'(bus_a.out_idx), 15);
      end
    end
    // Asynchronous reset between clock edges while done is high.
    #1 rst_in = 1'b1;
    #1;
    chk("e_async_ov",    0, 32'(bus_a.out_valid), 0);
    chk("e_async_busy",  0, 32'(bus_a.busy), 0);
    chk("e_async_done",  0, 32'(bus_a.done), 0);
    chk("e_async_state", 0, 32'(bus_a.dbg_state == IDLE), 1);
    #1 rst_in = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
